// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-requester line-transfer bus arbiter.
package bus_arbiter_pkg;

  // Words per cache line; the arbiter's LineWords parameter defaults to this.
  localparam int LINE_WORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_e;

  // 0 = fetch unit, 1 = load/store unit
  typedef logic req_idx_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// APB-like single-word bus between the arbiter (master) and the external slave.
interface bus_arbiter_if;
  logic [31:0] addr;
  logic        select;
  logic        enable;
  logic        write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output addr, select, enable, write, wdata,
    input  rdata, ready
  );

  modport slave (
    input  addr, select, enable, write, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/bus_arbiter_round_robin_picker.sv
// Two-way round-robin choice: a lone request wins, a tie goes to the requester
// that did not own the bus last.
module round_robin_picker
  import bus_arbiter_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  req_idx_t last_owner,
  output logic     any_req,
  output req_idx_t winner
);

  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      winner = ~last_owner;
    end else if (req1) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one APB-like bus between fetch (0) and load/store (1); each grant moves
// one cache line as LineWords sequential setup/access word transfers.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int LineWords = LINE_WORDS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req0,
  input  logic                         req1,
  input  logic                         write0,
  input  logic                         write1,
  input  logic [31:0]                  addr0,
  input  logic [31:0]                  addr1,
  input  logic [31:0]                  wdata0,
  input  logic [31:0]                  wdata1,
  output logic                         grant0,
  output logic                         grant1,
  output logic [$clog2(LineWords)-1:0] beat,
  output logic                         rvalid0,
  output logic                         rvalid1,
  output logic [31:0]                  rdataOut,
  output logic                         done0,
  output logic                         done1,
  bus_arbiter_if.master                bus
);

  localparam int BeatW = $clog2(LineWords);
  localparam int LineW = 32 - BeatW - 2;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(LineWords - 1);

  state_e             state_q, state_d;
  req_idx_t           owner_q, owner_d;
  logic               write_q, write_d;
  logic [LineW-1:0]   line_q, line_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [31:0]        rdata_out_q, rdata_out_d;
  logic               rvalid0_q, rvalid0_d;
  logic               rvalid1_q, rvalid1_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;

  logic               any_req;
  req_idx_t           winner;
  logic               select;
  logic               unused_addr_bits;

  // Word-offset bits of the requested line address are not used.
  assign unused_addr_bits = ^{addr0[BeatW+1:0], addr1[BeatW+1:0]};

  round_robin_picker u_picker (
    .req0       (req0),
    .req1       (req1),
    .last_owner (owner_q),
    .any_req    (any_req),
    .winner     (winner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    write_d     = write_q;
    line_d      = line_q;
    beat_d      = beat_q;
    rdata_out_d = rdata_out_q;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = winner;
          write_d = winner ? write1 : write0;
          line_d  = winner ? addr1[31:BeatW+2] : addr0[31:BeatW+2];
          beat_d  = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.ready) begin
          if (!write_q) begin
            rdata_out_d = bus.rdata;
            rvalid0_d   = ~owner_q;
            rvalid1_d   = owner_q;
          end
          if (beat_q == LastBeat) begin
            done0_d = ~owner_q;
            done1_d = owner_q;
            state_d = ST_IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = ST_SETUP;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b1;
      write_q     <= 1'b0;
      line_q      <= '0;
      beat_q      <= '0;
      rdata_out_q <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      line_q      <= line_d;
      beat_q      <= beat_d;
      rdata_out_q <= rdata_out_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
    end
  end

  // Bus outputs are forced to zero outside a transfer so reset clears them at once.
  assign select     = (state_q != ST_IDLE);
  assign bus.select = select;
  assign bus.enable = (state_q == ST_ACCESS);
  assign bus.write  = select & write_q;
  assign bus.addr   = select ? {line_q, beat_q, 2'b00} : '0;
  assign bus.wdata  = (select && write_q) ? (owner_q ? wdata1 : wdata0) : '0;

  // The owner keeps its grant through the done cycle, which is already IDLE.
  assign grant0   = (select & ~owner_q) | done0_q;
  assign grant1   = (select & owner_q) | done1_q;
  assign beat     = beat_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdataOut = rdata_out_q;
  assign done0    = done0_q;
  assign done1    = done1_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a line-level model predicts transfers, reads
// and completions; a negedge monitor compares them against the bus.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int LW = 4;
  localparam logic [31:0] LINE_MASK = 32'(LW * 4 - 1);

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          owner;
    int          beat;
  } xfer_t;

  typedef struct {
    int          owner;
    logic [31:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        write0 = 1'b0, write1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [31:0] wbase0 = '0, wbase1 = '0;
  logic [31:0] wdata0, wdata1;
  logic        grant0, grant1;
  logic [1:0]  beat;
  logic        rvalid0, rvalid1;
  logic [31:0] rdataOut;
  logic        done0, done1;

  xfer_t exp_xfer[$];
  rd_t   exp_rd[$];
  int    exp_done[$];
  int    last_owner = 1;
  int    checks = 0;
  int    errors = 0;
  int    wait_mode = 0;
  int    wait_left = 0;

  always #5 clk = ~clk;

  bus_arbiter_if bus();

  bus_arbiter #(.LineWords(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .write0   (write0),
    .write1   (write1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .grant0   (grant0),
    .grant1   (grant1),
    .beat     (beat),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdataOut (rdataOut),
    .done0    (done0),
    .done1    (done1),
    .bus      (bus)
  );

  function automatic logic [31:0] rfun(input logic [31:0] a);
    return {~a[15:0], a[31:16]};
  endfunction

  assign bus.rdata = rfun(bus.addr);
  assign wdata0 = wbase0 + 32'(beat);
  assign wdata1 = wbase1 + 32'(beat);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none at %0t", name, $time);
  endtask

  // Line-level model: LW consecutive word addresses from the aligned line base.
  function automatic void push_txn(input int owner, input logic [31:0] a,
                                   input logic wr, input logic [31:0] wb);
    xfer_t x;
    rd_t   r;
    logic [31:0] base;
    base = a & ~LINE_MASK;
    for (int i = 0; i < LW; i++) begin
      x.addr  = base + 32'(4 * i);
      x.wr    = wr;
      x.wdata = wr ? wb + 32'(i) : 32'h0;
      x.owner = owner;
      x.beat  = i;
      exp_xfer.push_back(x);
      if (!wr) begin
        r.owner = owner;
        r.data  = rfun(x.addr);
        exp_rd.push_back(r);
      end
    end
    exp_done.push_back(owner);
  endfunction

  // Slave: chooses per-word wait count during setup, then holds ready low for it.
  initial begin
    bus.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.select && !bus.enable) begin
        case (wait_mode)
          0:       wait_left = 0;
          1:       wait_left = int'($urandom_range(0, 2));
          default: wait_left = (beat == 2'd2) ? 3 : 0;
        endcase
        bus.ready = 1'b0;
      end else if (bus.select && bus.enable) begin
        if (wait_left > 0) begin
          bus.ready = 1'b0;
          wait_left--;
        end else begin
          bus.ready = 1'b1;
        end
      end else begin
        bus.ready = 1'b0;
      end
    end
  end

  // Monitor
  initial begin
    xfer_t x;
    rd_t   r;
    int    d;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.select && bus.enable) begin
          if (exp_xfer.size() == 0) begin
            unexpected("xfer_unexpected");
          end else begin
            x = exp_xfer[0];
            check("xfer_addr", bus.addr, x.addr);
            check("xfer_beat", 32'(beat), 32'(x.beat));
            if (bus.ready) begin
              check("xfer_write", 32'(bus.write), 32'(x.wr));
              check("xfer_wdata", bus.wdata, x.wdata);
              check("xfer_grant", {30'b0, grant1, grant0}, (x.owner == 1) ? 32'd2 : 32'd1);
              void'(exp_xfer.pop_front());
            end
          end
        end
        if (rvalid0 || rvalid1) begin
          if (exp_rd.size() == 0) begin
            unexpected("rvalid_unexpected");
          end else begin
            r = exp_rd.pop_front();
            check("rvalid_who", {30'b0, rvalid1, rvalid0}, (r.owner == 1) ? 32'd2 : 32'd1);
            check("rdata_out", rdataOut, r.data);
          end
        end
        if (done0 || done1) begin
          if (exp_done.size() == 0) begin
            unexpected("done_unexpected");
          end else begin
            d = exp_done.pop_front();
            check("done_who", {30'b0, done1, done0}, (d == 1) ? 32'd2 : 32'd1);
          end
        end
      end
    end
  end

  task automatic run_txn(input bit r0, input bit r1, input bit wr0, input bit wr1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] wb0, input logic [31:0] wb1,
                         input bit drop0, output int lat);
    int  cyc;
    bit  fin0, fin1;
    addr0 = a0; addr1 = a1; write0 = wr0; write1 = wr1;
    wbase0 = wb0; wbase1 = wb1;
    if (r0 && r1) begin
      if (last_owner == 1) begin
        push_txn(0, a0, wr0, wb0); push_txn(1, a1, wr1, wb1); last_owner = 1;
      end else begin
        push_txn(1, a1, wr1, wb1); push_txn(0, a0, wr0, wb0); last_owner = 0;
      end
    end else if (r0) begin
      push_txn(0, a0, wr0, wb0); last_owner = 0;
    end else begin
      push_txn(1, a1, wr1, wb1); last_owner = 1;
    end
    req0 = r0; req1 = r1;
    fin0 = !r0; fin1 = !r1;
    lat = -1; cyc = 0;
    while (!(fin0 && fin1) && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done0) begin req0 = 1'b0; fin0 = 1'b1; if (lat < 0) lat = cyc; end
      if (done1) begin req1 = 1'b0; fin1 = 1'b1; if (lat < 0) lat = cyc; end
      // Latched request fields must not follow later changes.
      if (grant0 && !fin0) begin addr0 = $urandom; write0 = 1'($urandom); end
      if (grant1 && !fin1) begin addr1 = $urandom; write1 = 1'($urandom); end
      if (drop0 && grant0 && beat != 2'd0) req0 = 1'b0;
    end
    if (!(fin0 && fin1)) begin
      unexpected("txn_timeout");
      req0 = 1'b0; req1 = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, {30'b0, grant1, grant0}, 32'h0);
    check({tag, "_beat"}, 32'(beat), 32'h0);
    check({tag, "_pulses"}, {28'b0, rvalid0, rvalid1, done0, done1}, 32'h0);
    check({tag, "_rdataout"}, rdataOut, 32'h0);
    check({tag, "_busctl"}, {29'b0, bus.select, bus.enable, bus.write}, 32'h0);
    check({tag, "_addr"}, bus.addr, 32'h0);
    check({tag, "_wdata"}, bus.wdata, 32'h0);
  endtask

  initial begin
    int lat;
    int pat;
    int cyc;
    #3;
    check_all_zero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    wait_mode = 0;
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h1000_0010, 32'h0, 32'h0, 32'h0, 1'b0, lat);
    check("read_latency", 32'(lat), 32'd9);
    run_txn(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h2000_0000, 32'h0, 32'hA0, 1'b0, lat);
    check("write_latency", 32'(lat), 32'd9);
    run_txn(1'b1, 1'b1, 1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom, 1'b0, lat);
    run_txn(1'b1, 1'b1, 1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom, 1'b0, lat);

    wait_mode = 2;
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h3000_0040, 32'h0, 32'h0, 32'h0, 1'b0, lat);
    check("wait_latency", 32'(lat), 32'd12);

    wait_mode = 0;
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h4000_0100, 32'h0, 32'h0, 32'h0, 1'b1, lat);
    check("drop_latency", 32'(lat), 32'd9);

    wait_mode = 1;
    for (int i = 0; i < 24; i++) begin
      pat = int'($urandom_range(1, 3));
      run_txn(pat[0], pat[1], 1'($urandom), 1'($urandom), $urandom, $urandom,
              $urandom, $urandom, 1'b0, lat);
    end

    // Reset in the access phase of beat 1.
    wait_mode = 0;
    addr0 = 32'h5000_0020; write0 = 1'b0;
    push_txn(0, addr0, 1'b0, 32'h0);
    req0 = 1'b1;
    cyc = 0;
    while (!(beat == 2'd1 && bus.enable) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 50) unexpected("rst_wait_timeout");
    check("pre_rst_rdataout", 32'(rdataOut != 32'h0), 32'd1);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_xfer.delete(); exp_rd.delete(); exp_done.delete();
    last_owner = 1;
    req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midrst_no_done", {30'b0, done1, done0}, 32'h0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b1, 1'b1, 1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom, 1'b0, lat);
    check("post_rst_latency", 32'(lat), 32'd9);

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("left_xfers", 32'(exp_xfer.size()), 32'd0);
    check("left_reads", 32'(exp_rd.size()), 32'd0);
    check("left_dones", 32'(exp_done.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
